// File: rtl/coreriscv_axi4_alu_pkg.sv
// Shared definitions for the handshaked integer ALU: function codes, FSM states and fn decode helpers.
package coreriscv_axi4_alu_pkg;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SL   = 4'd1;
  localparam logic [3:0] FN_SEQ  = 4'd2;
  localparam logic [3:0] FN_SNE  = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_SR   = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_AND  = 4'd7;
  localparam logic [3:0] FN_SUB  = 4'd10;
  localparam logic [3:0] FN_SRA  = 4'd11;
  localparam logic [3:0] FN_SLT  = 4'd12;
  localparam logic [3:0] FN_SGE  = 4'd13;
  localparam logic [3:0] FN_SLTU = 4'd14;
  localparam logic [3:0] FN_SGEU = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic fn_is_sub(input logic [3:0] fn);
    return fn[3];
  endfunction

  function automatic logic fn_is_cmp(input logic [3:0] fn);
    return (fn == FN_SEQ) || (fn == FN_SNE) || (fn >= FN_SLT);
  endfunction

  function automatic logic fn_cmp_unsigned(input logic [3:0] fn);
    return (fn == FN_SLTU) || (fn == FN_SGEU);
  endfunction

  function automatic logic fn_cmp_inverted(input logic [3:0] fn);
    return (fn == FN_SNE) || (fn == FN_SGE) || (fn == FN_SGEU);
  endfunction

  function automatic logic fn_is_shift(input logic [3:0] fn);
    return (fn == FN_SL) || (fn == FN_SR) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/coreriscv_axi4_alu_shstep.sv
// One step of the iterative shifter: shifts val_i by amt_i (<= SHIFT_STEP) left, or right with fill_i.
module coreriscv_axi4_alu_shstep #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  localparam int AMT_W     = $clog2(SHIFT_STEP) + 1
) (
  input  logic [XLEN-1:0]  val_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             left_i,
  input  logic             fill_i,
  output logic [XLEN-1:0]  val_o
);

  always_comb begin
    if (left_i) begin
      val_o = val_i << amt_i;
    end else begin
      val_o = (val_i >> amt_i) | ({XLEN{fill_i}} & ~({XLEN{1'b1}} >> amt_i));
    end
  end

endmodule

// File: rtl/coreriscv_axi4_alu_pipe.sv
// Handshaked integer ALU with registered response, tag and flush.
// Define CORERISCV_AXI4_ALU_ITER_SHIFT_EN to run shifts iteratively; otherwise a barrel shifter is used.
module coreriscv_axi4_alu_pipe
  import coreriscv_axi4_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [3:0]       io_req_fn,
  input  logic             io_req_dw,
  input  logic [XLEN-1:0]  io_req_in1,
  input  logic [XLEN-1:0]  io_req_in2,
  input  logic [TAG_W-1:0] io_req_tag,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_data,
  output logic [XLEN-1:0]  io_resp_adder_out,
  output logic             io_resp_cmp_out,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic             io_busy
);

  localparam int SH_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return XLEN'($signed(x[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  alu_state_e       state_q, state_d;
  logic [XLEN-1:0]  adder_q, adder_d, data_q, data_d;
  logic             cmp_q, cmp_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept, wop, left, fill, cmp_base, cmp_now;
  logic [XLEN-1:0]  adder_now, sh_src, shift_res, res_now;
  logic [SH_W-1:0]  sh_amt;

  assign io_req_ready = !io_flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && io_resp_ready));
  assign accept = io_req_valid && io_req_ready;
  assign wop    = (XLEN == 64) && !io_req_dw;

  // Request decode: adder, compare and shift operand preparation
  always_comb begin
    adder_now = io_req_in1 + (io_req_in2 ^ {XLEN{fn_is_sub(io_req_fn)}})
              + XLEN'(fn_is_sub(io_req_fn));
    if (!io_req_fn[3])                   cmp_base = (io_req_in1 == io_req_in2);
    else if (fn_cmp_unsigned(io_req_fn)) cmp_base = (io_req_in1 < io_req_in2);
    else                                 cmp_base = ($signed(io_req_in1) < $signed(io_req_in2));
    cmp_now = fn_is_cmp(io_req_fn) && (cmp_base ^ fn_cmp_inverted(io_req_fn));

    sh_amt = wop ? SH_W'(io_req_in2[4:0]) : io_req_in2[SH_W-1:0];
    sh_src = io_req_in1;
    if (wop && (io_req_fn == FN_SR))  sh_src = XLEN'(io_req_in1[31:0]);
    if (wop && (io_req_fn == FN_SRA)) sh_src = sext_w(io_req_in1);
    left = (io_req_fn == FN_SL);
    fill = (io_req_fn == FN_SRA) && sh_src[XLEN-1];
  end

`ifdef CORERISCV_AXI4_ALU_ITER_SHIFT_EN
  localparam int AMT_W = $clog2(SHIFT_STEP) + 1;
  localparam logic [SH_W-1:0] STEP_C = SH_W'(SHIFT_STEP);

  logic [XLEN-1:0] val_q, val_d, step_val;
  logic [SH_W-1:0] rem_q, rem_d, step_amt;
  logic            left_q, left_d, fill_q, fill_d, wop_q, wop_d;

  // Only a zero-distance shift completes at accept; it still needs word sign-extension
  assign shift_res = wop ? sext_w(sh_src) : sh_src;
  assign step_amt  = (rem_q > STEP_C) ? STEP_C : rem_q;

  coreriscv_axi4_alu_shstep #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shstep (
    .val_i  (val_q),
    .amt_i  (AMT_W'(step_amt)),
    .left_i (left_q),
    .fill_i (fill_q),
    .val_o  (step_val)
  );

  always_ff @(posedge clk) begin
    val_q  <= val_d;
    rem_q  <= rem_d;
    left_q <= left_d;
    fill_q <= fill_d;
    wop_q  <= wop_d;
  end
`else
  logic [XLEN-1:0] sh_in, sh_out;

  // Left shifts reuse the right shifter on bit-reversed operands
  always_comb begin
    sh_in     = left ? bitrev(sh_src) : sh_src;
    sh_out    = (sh_in >> sh_amt) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> sh_amt));
    shift_res = left ? bitrev(sh_out) : sh_out;
    if (wop) shift_res = sext_w(shift_res);
  end
`endif

  always_comb begin
    case (io_req_fn)
      FN_ADD, FN_SUB:                res_now = wop ? sext_w(adder_now) : adder_now;
      FN_XOR:                        res_now = io_req_in1 ^ io_req_in2;
      FN_OR:                         res_now = io_req_in1 | io_req_in2;
      FN_AND:                        res_now = io_req_in1 & io_req_in2;
      FN_SEQ, FN_SNE, FN_SLT, FN_SGE,
      FN_SLTU, FN_SGEU:              res_now = XLEN'(cmp_now);
      FN_SL, FN_SR, FN_SRA:          res_now = shift_res;
      default:                       res_now = '0;
    endcase
  end

  // Next-state: flush overrides everything, accept overrides the DONE drain
  always_comb begin
    state_d = state_q;
    adder_d = adder_q;
    data_d  = data_q;
    cmp_d   = cmp_q;
    tag_d   = tag_q;
`ifdef CORERISCV_AXI4_ALU_ITER_SHIFT_EN
    val_d  = val_q;
    rem_d  = rem_q;
    left_d = left_q;
    fill_d = fill_q;
    wop_d  = wop_q;
`endif
    case (state_q)
`ifdef CORERISCV_AXI4_ALU_ITER_SHIFT_EN
      ST_SHIFT: begin
        val_d = step_val;
        rem_d = rem_q - step_amt;
        if (rem_d == '0) begin
          state_d = ST_DONE;
          data_d  = wop_q ? sext_w(step_val) : step_val;
        end
      end
`endif
      ST_DONE: if (io_resp_ready && !io_req_valid) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      adder_d = adder_now;
      cmp_d   = cmp_now;
      tag_d   = io_req_tag;
      data_d  = res_now;
      state_d = ST_DONE;
`ifdef CORERISCV_AXI4_ALU_ITER_SHIFT_EN
      if (fn_is_shift(io_req_fn) && (sh_amt != '0)) begin
        state_d = ST_SHIFT;
        data_d  = data_q;
        val_d   = sh_src;
        rem_d   = sh_amt;
        left_d  = left;
        fill_d  = fill;
        wop_d   = wop;
      end
`endif
    end
    if (io_flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      adder_q <= '0;
      data_q  <= '0;
      cmp_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      adder_q <= adder_d;
      data_q  <= data_d;
      cmp_q   <= cmp_d;
      tag_q   <= tag_d;
    end
  end

  assign io_resp_valid     = (state_q == ST_DONE);
  assign io_busy           = (state_q != ST_IDLE);
  assign io_resp_data      = data_q;
  assign io_resp_adder_out = adder_q;
  assign io_resp_cmp_out   = cmp_q;
  assign io_resp_tag       = tag_q;

endmodule

// File: tb/tb_coreriscv_axi4_alu_pipe.sv
// Self-checking bench for coreriscv_axi4_alu_pipe (XLEN=64) against a behavioural RV ALU model.
module tb_coreriscv_axi4_alu_pipe;

  localparam int XL   = 64;
  localparam int TW   = 5;
  localparam int STEP = 4;
`ifdef CORERISCV_AXI4_ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          io_flush;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_fn;
  logic          req_dw;
  logic [XL-1:0] req_in1, req_in2;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic [XL-1:0] resp_data, resp_adder;
  logic          resp_cmp;
  logic [TW-1:0] resp_tag;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  coreriscv_axi4_alu_pipe #(.XLEN(XL), .TAG_W(TW), .SHIFT_STEP(STEP)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_flush          (io_flush),
    .io_req_valid      (req_valid),
    .io_req_ready      (req_ready),
    .io_req_fn         (req_fn),
    .io_req_dw         (req_dw),
    .io_req_in1        (req_in1),
    .io_req_in2        (req_in2),
    .io_req_tag        (req_tag),
    .io_resp_valid     (resp_valid),
    .io_resp_ready     (resp_ready),
    .io_resp_data      (resp_data),
    .io_resp_adder_out (resp_adder),
    .io_resp_cmp_out   (resp_cmp),
    .io_resp_tag       (resp_tag),
    .io_busy           (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  function automatic logic [63:0] ref_data(input logic [3:0] f, input logic d,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [31:0] aw, bw;
    logic signed [63:0] sa, sb;
    logic signed [31:0] saw;
    int unsigned sh;
    aw = a[31:0]; bw = b[31:0];
    sa = a; sb = b; saw = aw;
    sh = d ? int'(b[5:0]) : int'(b[4:0]);
    case (f)
      4'd0:  return d ? a + b : sext32(aw + bw);
      4'd10: return d ? a - b : sext32(aw - bw);
      4'd1:  return d ? a << sh : sext32(aw << sh);
      4'd5:  return d ? a >> sh : sext32(aw >> sh);
      4'd11: begin
        sa  = sa >>> sh;
        saw = saw >>> sh;
        return d ? sa : sext32(saw);
      end
      4'd4:  return a ^ b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd2:  return 64'(a == b);
      4'd3:  return 64'(a != b);
      4'd12: return 64'(sa < sb);
      4'd13: return 64'(sa >= sb);
      4'd14: return 64'(a < b);
      4'd15: return 64'(a >= b);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_cmp(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    if (f == 2 || f == 3 || f >= 12) return ref_data(f, 1'b1, a, b) != 0;
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_adder(input logic [3:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
    return f[3] ? a - b : a + b;
  endfunction

  function automatic int ref_lat(input logic [3:0] f, input logic d, input logic [63:0] b);
    int sh;
    if (ITER && (f == 1 || f == 5 || f == 11)) begin
      sh = d ? int'(b[5:0]) : int'(b[4:0]);
      return 1 + (sh + STEP - 1) / STEP;
    end
    return 1;
  endfunction

  // ---------------- driver (no checking) ----------------
  task automatic run_op(input logic [3:0] f, input logic d, input logic [63:0] a,
                        input logic [63:0] b, input logic [TW-1:0] t,
                        output logic [63:0] od, output logic [63:0] oa,
                        output logic oc, output logic [TW-1:0] ot, output int olat);
    int w;
    req_fn = f; req_dw = d; req_in1 = a; req_in2 = b; req_tag = t;
    req_valid = 1'b1; resp_ready = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    olat = -2; od = 'x; oa = 'x; oc = 1'bx; ot = 'x;
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    olat = 1;
    while (!resp_valid && olat < 100) begin @(posedge clk); #1; olat++; end
    if (!resp_valid) olat = -1;
    od = resp_data; oa = resp_adder; oc = resp_cmp; ot = resp_tag;
  endtask

  task automatic settle();
    req_valid = 1'b0; resp_ready = 1'b1; io_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; io_flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_fn = '0; req_dw = 1'b1; req_in1 = '0; req_in2 = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({resp_data, resp_adder, resp_cmp, resp_tag} !== '0) begin
      bad++; $display("FAIL reset_fields data=%h adder=%h cmp=%b tag=%h want all 0",
                      resp_data, resp_adder, resp_cmp, resp_tag);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  fn;
    logic        dw;
    logic [63:0] a, b;
    logic [63:0] data;
    logic        cmp;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[6];
    logic [63:0] od, oa; logic oc; logic [TW-1:0] ot; int ol;
    tbl[0] = '{4'd10, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[1] = '{4'd10, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[2] = '{4'd11, 1'b0, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b0};
    tbl[3] = '{4'd14, 1'b1, 64'd1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1};
    tbl[4] = '{4'd13, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0, 1'b0};
    tbl[5] = '{4'd5,  1'b0, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1, 1'b0};
    settle();
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].fn, tbl[i].dw, tbl[i].a, tbl[i].b, TW'(i + 20), od, oa, oc, ot, ol);
      total++; if (od !== tbl[i].data) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", i, od, tbl[i].data); end
      total++; if (oc !== tbl[i].cmp) begin bad++; $display("FAIL dir%0d_cmp got=%b want=%b", i, oc, tbl[i].cmp); end
      total++; if (oa !== ref_adder(tbl[i].fn, tbl[i].a, tbl[i].b)) begin
        bad++; $display("FAIL dir%0d_adder got=%h want=%h", i, oa, ref_adder(tbl[i].fn, tbl[i].a, tbl[i].b));
      end
      total++; if (ol != ref_lat(tbl[i].fn, tbl[i].dw, tbl[i].b)) begin
        bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, ol, ref_lat(tbl[i].fn, tbl[i].dw, tbl[i].b));
      end
    end
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 64'($urandom_range(0, 70));
      1: return 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 3));
      2: return {32'h0, $urandom};
      3: return {{32{1'b1}}, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] od, oa, a, b; logic oc, d; logic [3:0] f; logic [TW-1:0] t, ot; int ol;
    settle();
    for (int i = 0; i < 150; i++) begin
      f = 4'($urandom_range(0, 15)); d = 1'($urandom); t = TW'($urandom);
      a = rand_operand(); b = rand_operand();
      run_op(f, d, a, b, t, od, oa, oc, ot, ol);
      total++; if (od !== ref_data(f, d, a, b)) begin
        bad++; $display("FAIL rnd%0d_data fn=%0d dw=%b a=%h b=%h got=%h want=%h", i, f, d, a, b, od, ref_data(f, d, a, b));
      end
      total++; if (oa !== ref_adder(f, a, b)) begin
        bad++; $display("FAIL rnd%0d_adder fn=%0d got=%h want=%h", i, f, oa, ref_adder(f, a, b));
      end
      total++; if (oc !== ref_cmp(f, a, b)) begin
        bad++; $display("FAIL rnd%0d_cmp fn=%0d got=%b want=%b", i, f, oc, ref_cmp(f, a, b));
      end
      total++; if (ot !== t) begin bad++; $display("FAIL rnd%0d_tag got=%h want=%h", i, ot, t); end
      total++; if (ol != ref_lat(f, d, b)) begin
        bad++; $display("FAIL rnd%0d_latency fn=%0d got=%0d want=%0d", i, f, ol, ref_lat(f, d, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a[4], b[4], xa, xb, ya, yb;
    settle();
    for (int i = 0; i < 4; i++) begin a[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom}; end
    for (int i = 0; i < 4; i++) begin
      req_fn = 4'd0; req_dw = 1'b1; req_in1 = a[i]; req_in2 = b[i]; req_tag = TW'(i); req_valid = 1'b1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_req_ready got=%b want=1", i, req_ready); end
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1 || resp_data !== a[i] + b[i] || resp_tag !== TW'(i)) begin
        bad++; $display("FAIL b2b%0d_resp valid=%b data=%h tag=%h want valid=1 data=%h tag=%h",
                        i, resp_valid, resp_data, resp_tag, a[i] + b[i], i);
      end
    end
    settle();
    xa = {$urandom, $urandom}; xb = {$urandom, $urandom};
    ya = {$urandom, $urandom}; yb = {$urandom, $urandom};
    resp_ready = 1'b0;
    req_fn = 4'd0; req_in1 = xa; req_in2 = xb; req_tag = TW'(7); req_valid = 1'b1;
    @(posedge clk); #1;
    req_in1 = ya; req_in2 = yb; req_tag = TW'(8);
    for (int k = 0; k < 3; k++) begin
      total++; if (resp_valid !== 1'b1 || resp_data !== xa + xb || resp_tag !== TW'(7) || req_ready !== 1'b0) begin
        bad++; $display("FAIL stall%0d valid=%b data=%h tag=%h req_ready=%b want 1/%h/07/0",
                        k, resp_valid, resp_data, resp_tag, req_ready, xa + xb);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_data !== ya + yb || resp_tag !== TW'(8)) begin
      bad++; $display("FAIL stall_release data=%h tag=%h want %h/08", resp_data, resp_tag, ya + yb);
    end
  endtask

  task automatic test_flush();
    logic [63:0] od, oa; logic oc; logic [TW-1:0] ot; int ol; int seen;
    settle();
    resp_ready = 1'b0;
    req_fn = 4'd0; req_dw = 1'b1; req_in1 = 64'd3; req_in2 = 64'd4; req_tag = TW'(9); req_valid = 1'b1;
    @(posedge clk); #1;
    req_in1 = 64'd10; req_tag = TW'(10); resp_ready = 1'b1; io_flush = 1'b1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_done_req_ready got=%b want=0", req_ready); end
    @(posedge clk); #1;
    io_flush = 1'b0; req_valid = 1'b0;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_done_after valid=%b busy=%b want 0/0", resp_valid, busy);
    end
`ifdef CORERISCV_AXI4_ALU_ITER_SHIFT_EN
    req_fn = 4'd1; req_dw = 1'b1; req_in1 = 64'd1; req_in2 = 64'd31; req_tag = TW'(11); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_shift_pre busy=%b valid=%b want 1/0", busy, resp_valid);
    end
    io_flush = 1'b1; req_fn = 4'd0; req_valid = 1'b1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_shift_req_ready got=%b want=0", req_ready); end
    @(posedge clk); #1;
    io_flush = 1'b0; req_valid = 1'b0;
    total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_shift_after busy=%b valid=%b want 0/0", busy, resp_valid);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (resp_valid === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_shift_late_resp got=%0d want=0", seen); end
`endif
    run_op(4'd0, 1'b1, 64'd40, 64'd2, TW'(12), od, oa, oc, ot, ol);
    total++; if (od !== 64'd42 || ot !== TW'(12) || ol != 1) begin
      bad++; $display("FAIL flush_next data=%h tag=%h lat=%0d want 2a/0c/1", od, ot, ol);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] od, oa; logic oc; logic [TW-1:0] ot; int ol;
    settle();
    resp_ready = 1'b0;
    req_fn = 4'd1; req_dw = 1'b1; req_in1 = 64'd1; req_in2 = 64'd31; req_tag = TW'(13); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL areset_pre_busy got=%b want=1", busy); end
    #2 reset = 1'b1;
    #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL areset_immediate valid=%b ready=%b busy=%b want 0/1/0", resp_valid, req_ready, busy);
    end
    @(negedge clk); reset = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    run_op(4'd1, 1'b1, 64'd1, 64'd63, TW'(14), od, oa, oc, ot, ol);
    total++; if (od !== 64'h8000_0000_0000_0000 || ol != ref_lat(4'd1, 1'b1, 64'd63)) begin
      bad++; $display("FAIL areset_next data=%h lat=%0d want 8000000000000000/%0d", od, ol, ref_lat(4'd1, 1'b1, 64'd63));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
